// File: rtl/mult4_mac_seq_if.sv
// Purpose: bundles the operand stream, the multiplier handshake and the group-sum outputs.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on the operand side, m_start/m_done toward the multiplier.
interface mult4_mac_seq_if #(
  parameter int ACC_W = 12
);
  // operand stream into the sequencer
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  // sequential multiplier handshake
  logic             m_start;
  logic [3:0]       m_a;
  logic [3:0]       m_b;
  logic             m_done;
  logic [7:0]       m_p;
  // group result
  logic             sum_valid;
  logic [ACC_W-1:0] sum;
  logic [7:0]       sum_cnt;
  logic             ovf;
  logic             tmo_err;

  // environment side: feeds operands, plays the multiplier, observes results
  modport master (
    output in_valid, in_a, in_b, in_last, m_done, m_p,
    input  in_ready, m_start, m_a, m_b, sum_valid, sum, sum_cnt, ovf, tmo_err
  );

  // sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_last, m_done, m_p,
    output in_ready, m_start, m_a, m_b, sum_valid, sum, sum_cnt, ovf, tmo_err
  );
endinterface

// File: rtl/mult4_mac_seq.sv
// Purpose: buffers operand pairs, issues them to a 4-bit sequential multiplier, accumulates group sums.
// Latency: per pair 1 (IDLE) + 1 (ISSUE) + multiplier latency + 1 (CAPTURE); +1 EMIT cycle on last pair.
// Backpressure: in_ready drops when the operand FIFO is full; FIFO accepts in every FSM state.
module mult4_mac_seq #(
  parameter int DEPTH   = 4,
  parameter int ACC_W   = 12,
  parameter int TIMEOUT = 32
) (
  input  logic           ck,
  input  logic           res,
  mult4_mac_seq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_CAPTURE = 3'd4,
    S_EMIT    = 3'd5
  } state_t;

  // operand FIFO storage; entry = {last, a, b}
  logic [8:0]       fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [8:0]       fifo_head;

  // sequencer state and datapath
  state_t           state;
  state_t           state_nxt;
  logic             rdy_en;
  logic [3:0]       a_r;
  logic [3:0]       b_r;
  logic             last_r;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf_r;
  logic [ACC_W-1:0] sum_hold;
  logic [7:0]       cnt_hold;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_err_r;
  logic             tmo_hit;
  logic [ACC_W:0]   acc_add;

  // decoded per-state controls
  logic             start;
  logic             capture;
  logic             emit;
  logic             tmo_fire;

  // ------------------------------------------------------------------
  // operand FIFO
  // ------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt == CW'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  // rdy_en keeps in_ready low while reset is asserted
  assign bus.in_ready = rdy_en & ~fifo_full;
  assign fifo_push    = bus.in_valid & bus.in_ready;
  assign fifo_head    = fifo_mem[rd_ptr];

  // in_ready is held off until the first clock after reset release
  always_ff @(posedge ck or negedge res) begin
    if (!res) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  // pointer and occupancy bookkeeping; simultaneous push+pop leaves the count unchanged
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // FIFO payload storage needs no reset; only occupied slots are ever read
  always_ff @(posedge ck) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {bus.in_last, bus.in_a, bus.in_b};
  end

  // ------------------------------------------------------------------
  // sequencer FSM
  // ------------------------------------------------------------------
  // the wait-state budget is exhausted on the TIMEOUT-th cycle spent waiting
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge ck or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state: progress on m_done wins over a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!bus.m_done)  state_nxt = S_WAIT_HI;
        else if (tmo_hit) state_nxt = last_r ? S_EMIT : S_IDLE;
      end
      S_WAIT_HI: begin
        if (bus.m_done)   state_nxt = S_CAPTURE;
        else if (tmo_hit) state_nxt = last_r ? S_EMIT : S_IDLE;
      end
      S_CAPTURE: state_nxt = last_r ? S_EMIT : S_IDLE;
      S_EMIT:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // output decode: one control strobe per state
  always_comb begin
    fifo_pop = 1'b0;
    start    = 1'b0;
    capture  = 1'b0;
    emit     = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      S_IDLE:    fifo_pop = ~fifo_empty;
      S_ISSUE:   start    = 1'b1;
      S_WAIT_LO: tmo_fire = bus.m_done & tmo_hit;
      S_WAIT_HI: tmo_fire = ~bus.m_done & tmo_hit;
      S_CAPTURE: capture  = 1'b1;
      S_EMIT:    emit     = 1'b1;
      default:   fifo_pop = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // datapath
  // ------------------------------------------------------------------
  // operand registers load on pop and stay stable through ISSUE..CAPTURE
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      a_r    <= '0;
      b_r    <= '0;
      last_r <= 1'b0;
    end else if (fifo_pop) begin
      {last_r, a_r, b_r} <= fifo_head;
    end
  end

  // wait-cycle counter: cleared entering WAIT_LO (from ISSUE) and entering WAIT_HI
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_ISSUE:   tmo_cnt <= '0;
        S_WAIT_LO: tmo_cnt <= bus.m_done ? tmo_cnt + TW'(1) : '0;
        S_WAIT_HI: tmo_cnt <= tmo_cnt + TW'(1);
        default:   tmo_cnt <= tmo_cnt;
      endcase
    end
  end

  // a hung multiplier is remembered until reset
  always_ff @(posedge ck or negedge res) begin
    if (!res)          tmo_err_r <= 1'b0;
    else if (tmo_fire) tmo_err_r <= 1'b1;
  end

  // one extra bit catches the carry out of the accumulator
  assign acc_add = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.m_p};

  // accumulate on CAPTURE, clear the group once it has been emitted
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (capture) begin
      acc <= acc_add[ACC_W-1:0];
      if (acc_add[ACC_W]) ovf_r <= 1'b1;
      if (cnt != 8'hFF)   cnt   <= cnt + 8'd1;
    end else if (emit) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end
  end

  // sum/sum_cnt keep showing the last emitted group between EMITs
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      sum_hold <= '0;
      cnt_hold <= '0;
    end else if (emit) begin
      sum_hold <= acc;
      cnt_hold <= cnt;
    end
  end

  assign bus.m_start   = start;
  assign bus.m_a       = a_r;
  assign bus.m_b       = b_r;
  assign bus.sum_valid = emit;
  assign bus.sum       = emit ? acc : sum_hold;
  assign bus.sum_cnt   = emit ? cnt : cnt_hold;
  assign bus.ovf       = emit & ovf_r;
  assign bus.tmo_err   = tmo_err_r;

endmodule
